voice_envelope: RTL and testbench

Eight-voice ADSR envelope generator that produces the per-voice `voice_volumes` consumed by the Synthesizer mixer. It turns per-voice gate (note on/off) levels plus shared attack/decay/sustain/release settings into unsigned Q16.16 gain words. It updates once per envelope tick, sweeping the voices sequentially, one voice per clock.

---
 rtl/envelope_pkg.sv | 29 ++
 rtl/envelope_step.sv | 98 +++++++++
 rtl/voice_envelope.sv | 141 ++++++++++++++
 tb/tb_voice_envelope.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_pkg.sv
// envelope_pkg
// Shared definitions for the eight-voice ADSR envelope generator:
//   env_state_t  - per-voice envelope phase
//   VOICES_C     - number of voices
//   LEVEL_W      - width of a Q16.16 gain word
//   LEVEL_ONE    - unity gain (1.0 in Q16.16)
//   clamp_level  - limits a level to an upper bound
package envelope_pkg;

  localparam int VOICES_C = 8;
  localparam int LEVEL_W  = 32;
  localparam int STATE_W  = 3;

  localparam logic [LEVEL_W-1:0] LEVEL_ONE = 32'h0001_0000;

  typedef enum logic [STATE_W-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] value,
                                                      input logic [LEVEL_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/envelope_step.sv
// envelope_step
// Combinational next-state / next-level computation for a single voice.
// The top level time-multiplexes one instance across all voices.
// Ports:
//   state_i, level_i      current phase and gain of the voice being processed
//   trig_i                pending note-on trigger for that voice
//   gate_i                registered gate level for that voice
//   attack_rate_i         level increment per tick in ATTACK
//   decay_rate_i          level decrement per tick in DECAY
//   sustain_level_i       sustain target (clamped to MAX_LEVEL)
//   release_rate_i        level decrement per tick in RELEASE
//   state_o, level_o      updated phase and gain
module envelope_step
  import envelope_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_ONE
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               trig_i,
  input  logic               gate_i,
  input  logic [LEVEL_W-1:0] attack_rate_i,
  input  logic [LEVEL_W-1:0] decay_rate_i,
  input  logic [LEVEL_W-1:0] sustain_level_i,
  input  logic [LEVEL_W-1:0] release_rate_i,
  output logic [STATE_W-1:0] state_o,
  output logic [LEVEL_W-1:0] level_o
);

  env_state_t         cur_state;
  env_state_t         eff_state;
  env_state_t         next_state;
  logic [LEVEL_W-1:0] sustain_eff;
  logic [LEVEL_W-1:0] next_level;
  logic [LEVEL_W:0]   attack_sum;
  logic [LEVEL_W:0]   decay_diff;
  logic [LEVEL_W:0]   release_diff;

  // The extra top bit of each sum/difference flags overflow past 32 bits or
  // underflow below zero. A trigger or a falling gate first redirects the
  // phase, and the step of the redirected phase is applied in the same update.
  always_comb begin
    cur_state    = env_state_t'(state_i);
    sustain_eff  = clamp_level(sustain_level_i, MAX_LEVEL);
    attack_sum   = {1'b0, level_i} + {1'b0, attack_rate_i};
    decay_diff   = {1'b0, level_i} - {1'b0, decay_rate_i};
    release_diff = {1'b0, level_i} - {1'b0, release_rate_i};

    eff_state = cur_state;
    if (trig_i) begin
      eff_state = ENV_ATTACK;
    end else if (!gate_i && (cur_state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
      eff_state = ENV_RELEASE;
    end

    next_state = eff_state;
    next_level = level_i;
    case (eff_state)
      ENV_ATTACK: begin
        if ((attack_rate_i == '0) || (attack_sum >= {1'b0, MAX_LEVEL})) begin
          next_level = MAX_LEVEL;
          next_state = ENV_DECAY;
        end else begin
          next_level = attack_sum[LEVEL_W-1:0];
        end
      end
      ENV_DECAY: begin
        if ((decay_rate_i == '0) || decay_diff[LEVEL_W] ||
            (decay_diff[LEVEL_W-1:0] <= sustain_eff)) begin
          next_level = sustain_eff;
          next_state = ENV_SUSTAIN;
        end else begin
          next_level = decay_diff[LEVEL_W-1:0];
        end
      end
      ENV_SUSTAIN: begin
        next_level = sustain_eff;
      end
      ENV_RELEASE: begin
        if ((release_rate_i == '0) || release_diff[LEVEL_W] ||
            (release_diff[LEVEL_W-1:0] == '0)) begin
          next_level = '0;
          next_state = ENV_IDLE;
        end else begin
          next_level = release_diff[LEVEL_W-1:0];
        end
      end
      default: begin
        next_level = '0;
        next_state = ENV_IDLE;
      end
    endcase
  end

  assign state_o = next_state;
  assign level_o = next_level;

endmodule

// File: rtl/voice_envelope.sv
// voice_envelope
// Eight-voice ADSR envelope generator producing Q16.16 gain words. Once per
// envelope tick a sweep updates voices 0..VOICES-1 on consecutive clocks
// through a single shared envelope_step.
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   gate           per-voice note-on level (may be asynchronous to the tick)
//   attack_rate    level increment per tick in ATTACK
//   decay_rate     level decrement per tick in DECAY
//   sustain_level  sustain target, clamped to MAX_LEVEL
//   release_rate   level decrement per tick in RELEASE
//   voice_volumes  registered gain per voice
//   voice_active   bit i high while voice i is not IDLE
//   sweep_done     one-cycle pulse during voice VOICES-1's processing cycle
module voice_envelope
  import envelope_pkg::*;
#(
  parameter int                 VOICES    = VOICES_C,
  parameter int                 TICK_DIV  = 1024,
  parameter logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_ONE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [VOICES-1:0]  gate,
  input  logic [LEVEL_W-1:0] attack_rate,
  input  logic [LEVEL_W-1:0] decay_rate,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [LEVEL_W-1:0] release_rate,
  output logic [LEVEL_W-1:0] voice_volumes [VOICES-1:0],
  output logic [VOICES-1:0]  voice_active,
  output logic               sweep_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic               rst_sync_q;
  logic [PW-1:0]      presc_q;
  logic               sweep_busy_q;
  logic [IW-1:0]      sweep_idx_q;
  logic [VOICES-1:0]  gate_q;
  logic [VOICES-1:0]  trig_q;
  logic [VOICES-1:0]  trig_d;
  logic [VOICES-1:0]  clear_mask;
  logic               terminal;
  env_state_t         state_q [VOICES-1:0];
  logic [LEVEL_W-1:0] level_q [VOICES-1:0];
  logic [STATE_W-1:0] step_state;
  logic [LEVEL_W-1:0] step_level;

  // Reset asserts asynchronously but is released on a clock edge, so every
  // other register leaves reset in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  assign terminal = (presc_q == PW'(TICK_DIV - 1));

  // Prescaler and sweep sequencer; TICK_DIV >= VOICES+2 keeps sweeps apart.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      presc_q      <= '0;
      sweep_busy_q <= 1'b0;
      sweep_idx_q  <= '0;
    end else begin
      presc_q <= terminal ? '0 : presc_q + 1'b1;
      if (terminal) begin
        sweep_busy_q <= 1'b1;
        sweep_idx_q  <= '0;
      end else if (sweep_busy_q) begin
        if (sweep_idx_q == IW'(VOICES - 1)) begin
          sweep_busy_q <= 1'b0;
        end
        sweep_idx_q <= sweep_idx_q + 1'b1;
      end
    end
  end

  // A new rising edge is OR-ed in after the clear, so it survives a clear
  // landing in the same cycle.
  always_comb begin
    clear_mask = '0;
    if (sweep_busy_q) begin
      clear_mask[sweep_idx_q] = 1'b1;
    end
    trig_d = (trig_q & ~clear_mask) | (gate & ~gate_q);
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      gate_q <= '0;
      trig_q <= '0;
    end else begin
      gate_q <= gate;
      trig_q <= trig_d;
    end
  end

  envelope_step #(
    .MAX_LEVEL(MAX_LEVEL)
  ) u_step (
    .state_i        (state_q[sweep_idx_q]),
    .level_i        (level_q[sweep_idx_q]),
    .trig_i         (trig_q[sweep_idx_q]),
    .gate_i         (gate_q[sweep_idx_q]),
    .attack_rate_i  (attack_rate),
    .decay_rate_i   (decay_rate),
    .sustain_level_i(sustain_level),
    .release_rate_i (release_rate),
    .state_o        (step_state),
    .level_o        (step_level)
  );

  // Per-voice envelope registers; only the voice under the sweep index moves.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= ENV_IDLE;
        level_q[v] <= '0;
      end
    end else if (sweep_busy_q) begin
      state_q[sweep_idx_q] <= env_state_t'(step_state);
      level_q[sweep_idx_q] <= step_level;
    end
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      voice_volumes[v] = level_q[v];
      voice_active[v]  = (state_q[v] != ENV_IDLE);
    end
  end

  assign sweep_done = sweep_busy_q && (sweep_idx_q == IW'(VOICES - 1));

endmodule

// File: tb/tb_voice_envelope.sv
// tb_voice_envelope
// Self-checking bench for voice_envelope with TICK_DIV=16. A tick-level
// envelope model tracks every voice; directed tables and sequences check the
// ADSR shape, retrigger, short pulse, saturation, reset and sweep ordering.
module tb_voice_envelope;

  localparam int TDIV = 16;

  logic        clk;
  logic        reset_n;
  logic [7:0]  gate;
  logic [31:0] attackRate;
  logic [31:0] decayRate;
  logic [31:0] sustainLevel;
  logic [31:0] releaseRate;
  logic [31:0] vv [7:0];
  logic [7:0]  active;
  logic        done;

  int total = 0;
  int bad   = 0;
  bit modelCheck = 0;

  voice_envelope #(
    .VOICES   (8),
    .TICK_DIV (TDIV),
    .MAX_LEVEL(32'h0001_0000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gate         (gate),
    .attack_rate  (attackRate),
    .decay_rate   (decayRate),
    .sustain_level(sustainLevel),
    .release_rate (releaseRate),
    .voice_volumes(vv),
    .voice_active (active),
    .sweep_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: phases as plain integers, levels as signed 64-bit
  // arithmetic. cyc counts clock edges since reset release; the tick falls
  // every TDIV cycles starting at cycle TDIV and voice v is processed
  // v+1 cycles after that.
  localparam int P_OFF = 0, P_RISE = 1, P_FALL = 2, P_HOLD = 3, P_FADE = 4;
  localparam longint CAP = 64'h1_0000;

  int         cyc;
  int         mPhase [8];
  longint     mLevel [8];
  logic [7:0] mGateQ;
  logic [7:0] mPend;

  task automatic modelVoice(input int v);
    longint sus, nxt, a, d, r;
    a   = longint'({32'b0, attackRate});
    d   = longint'({32'b0, decayRate});
    r   = longint'({32'b0, releaseRate});
    sus = longint'({32'b0, sustainLevel});
    if (sus > CAP) sus = CAP;
    if (mPend[v]) mPhase[v] = P_RISE;
    else if (!mGateQ[v] && (mPhase[v] == P_RISE || mPhase[v] == P_FALL || mPhase[v] == P_HOLD))
      mPhase[v] = P_FADE;
    case (mPhase[v])
      P_RISE: begin
        nxt = mLevel[v] + a;
        if (a == 0 || nxt >= CAP) begin mLevel[v] = CAP; mPhase[v] = P_FALL; end
        else mLevel[v] = nxt;
      end
      P_FALL: begin
        nxt = mLevel[v] - d;
        if (d == 0 || nxt <= sus) begin mLevel[v] = sus; mPhase[v] = P_HOLD; end
        else mLevel[v] = nxt;
      end
      P_HOLD: mLevel[v] = sus;
      P_FADE: begin
        nxt = mLevel[v] - r;
        if (r == 0 || nxt <= 0) begin mLevel[v] = 0; mPhase[v] = P_OFF; end
        else mLevel[v] = nxt;
      end
      default: mLevel[v] = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc    = 0;
      mGateQ = '0;
      mPend  = '0;
      for (int v = 0; v < 8; v++) begin
        mPhase[v] = P_OFF;
        mLevel[v] = 0;
      end
    end else begin
      if (cyc >= 1) begin
        logic [7:0] clr;
        clr = '0;
        if (cyc >= TDIV + 1 && ((cyc - 1) % TDIV) < 8) begin
          modelVoice((cyc - 1) % TDIV);
          clr[(cyc - 1) % TDIV] = 1'b1;
        end
        mPend  = (mPend & ~clr) | (gate & ~mGateQ);
        mGateQ = gate;
      end
      cyc = cyc + 1;
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (reset_n && modelCheck) begin
      logic [7:0] expAct;
      logic       expDone;
      for (int v = 0; v < 8; v++) begin
        total++;
        if (vv[v] !== 32'(mLevel[v])) begin
          bad++;
          $display("[TB] FAIL model_level v%0d cyc%0d: got 0x%0h, want 0x%0h", v, cyc, vv[v], mLevel[v]);
        end
        expAct[v] = (mPhase[v] != P_OFF);
      end
      expDone = (cyc >= TDIV + 8) && ((cyc % TDIV) == 8);
      total++;
      if (active !== expAct) begin
        bad++;
        $display("[TB] FAIL model_active cyc%0d: got 0x%0h, want 0x%0h", cyc, active, expAct);
      end
      total++;
      if (done !== expDone) begin
        bad++;
        $display("[TB] FAIL model_done cyc%0d: got %0b, want %0b", cyc, done, expDone);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] g, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] s, input logic [31:0] r);
    gate         = g;
    attackRate   = a;
    decayRate    = d;
    sustainLevel = s;
    releaseRate  = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the negedge just after voice v's register update.
  task automatic waitTick(input int v);
    bit hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      if (cyc >= TDIV + 2 && (cyc % TDIV) == 2 + v) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL waitTick%0d: got timeout, want voice update", v);
    end
  endtask

  task automatic measureDone(input string name);
    int first = 0;
    for (int k = 1; k <= 60 && first == 0; k++) begin
      @(negedge clk);
      if (done) first = k;
    end
    checkOutput(name, first, 24);
  endtask

  typedef struct {
    bit          g0;
    logic [31:0] sus;
    logic [31:0] expLevel;
    bit          expActive;
  } adsrRow_t;

  adsrRow_t adsrTab [18];

  initial begin
    adsrTab[0]  = '{1'b1, 32'h8000, 32'h4000,  1'b1};
    adsrTab[1]  = '{1'b1, 32'h8000, 32'h8000,  1'b1};
    adsrTab[2]  = '{1'b1, 32'h8000, 32'hC000,  1'b1};
    adsrTab[3]  = '{1'b1, 32'h8000, 32'h10000, 1'b1};
    for (int i = 0; i < 8; i++)
      adsrTab[4 + i] = '{1'b1, 32'h8000, 32'hF000 - 32'(i) * 32'h1000, 1'b1};
    adsrTab[12] = '{1'b1, 32'hC000, 32'hC000,  1'b1};
    adsrTab[13] = '{1'b1, 32'h8000, 32'h8000,  1'b1};
    adsrTab[14] = '{1'b0, 32'h8000, 32'h6000,  1'b1};
    adsrTab[15] = '{1'b0, 32'h8000, 32'h4000,  1'b1};
    adsrTab[16] = '{1'b0, 32'h8000, 32'h2000,  1'b1};
    adsrTab[17] = '{1'b0, 32'h8000, 32'h0,     1'b0};

    reset_n = 1'b0;
    applyStimulus(8'h00, 32'h4000, 32'h1000, 32'h8000, 32'h2000);
    repeat (3) @(negedge clk);
    for (int v = 0; v < 8; v++) checkOutput($sformatf("reset_level%0d", v), vv[v], 32'h0);
    checkOutput("reset_active", {24'b0, active}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);

    // All gates rise together: voice i updates in cycle 18+i, done in cycle 24.
    $display("[TB] sweep ordering");
    gate       = 8'hFF;
    reset_n    = 1'b1;
    modelCheck = 1'b1;
    begin
      int firstDone = 0;
      for (int k = 1; k <= 25; k++) begin
        @(negedge clk);
        if (done && firstDone == 0) firstDone = k;
        for (int v = 0; v < 8; v++)
          checkOutput($sformatf("order_v%0d_c%0d", v, k), vv[v], (k >= 18 + v) ? 32'h4000 : 32'h0);
      end
      checkOutput("order_first_done", firstDone, 24);
    end

    // Reset asserted mid-way through the second sweep.
    $display("[TB] reset mid-sweep");
    waitTick(3);
    reset_n = 1'b0;
    #1;
    for (int v = 0; v < 8; v++) checkOutput($sformatf("midrst_level%0d", v), vv[v], 32'h0);
    checkOutput("midrst_active", {24'b0, active}, 32'h0);
    checkOutput("midrst_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    gate    = 8'h00;
    reset_n = 1'b1;
    measureDone("rst_release_done_latency");

    $display("[TB] ADSR table on voice 0");
    for (int i = 0; i < 18; i++) begin
      applyStimulus({gate[7:1], adsrTab[i].g0}, 32'h4000, 32'h1000, adsrTab[i].sus, 32'h2000);
      waitTick(0);
      checkOutput($sformatf("adsr_level_row%0d", i), vv[0], adsrTab[i].expLevel);
      checkOutput($sformatf("adsr_active_row%0d", i), {31'b0, active[0]}, {31'b0, adsrTab[i].expActive});
    end

    $display("[TB] retrigger from release");
    gate[0] = 1'b1;
    repeat (12) waitTick(0);
    checkOutput("retrig_sustain", vv[0], 32'h8000);
    gate[0] = 1'b0;
    waitTick(0);
    checkOutput("retrig_release", vv[0], 32'h6000);
    gate[0] = 1'b1;
    waitTick(0);
    checkOutput("retrig_attack", vv[0], 32'hA000);
    checkOutput("retrig_active", {31'b0, active[0]}, 32'h1);
    gate[0] = 1'b0;

    $display("[TB] short pulse on voice 5");
    waitTick(7);
    @(negedge clk);
    gate[5] = 1'b1;
    @(negedge clk);
    gate[5] = 1'b0;
    waitTick(5);
    checkOutput("pulse_attack", vv[5], 32'h4000);
    checkOutput("pulse_active1", {31'b0, active[5]}, 32'h1);
    waitTick(5);
    checkOutput("pulse_release", vv[5], 32'h2000);
    waitTick(5);
    checkOutput("pulse_zero", vv[5], 32'h0);
    checkOutput("pulse_idle", {31'b0, active[5]}, 32'h0);

    $display("[TB] saturation and zero rates on voice 2");
    applyStimulus(gate | 8'h04, 32'hFFFF_FFFF, 32'h1000, 32'h2_0000, 32'h2000);
    waitTick(2);
    checkOutput("sat_attack", vv[2], 32'h10000);
    waitTick(2);
    checkOutput("sat_decay_clamp", vv[2], 32'h10000);
    waitTick(2);
    checkOutput("sat_sustain", vv[2], 32'h10000);
    applyStimulus(gate & ~8'h04, 32'h4000, 32'h1000, 32'h2_0000, 32'h0);
    waitTick(2);
    checkOutput("zero_release_level", vv[2], 32'h0);
    checkOutput("zero_release_idle", {31'b0, active[2]}, 32'h0);
    applyStimulus(gate, 32'h4000, 32'h1000, 32'h8000, 32'h2000);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) gate = gate ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) begin
        case ($urandom_range(0, 3))
          0:       attackRate = 32'h0;
          1:       attackRate = 32'hFFFF_FFFF;
          default: attackRate = $urandom_range(1, 32'h2_0000);
        endcase
        decayRate    = $urandom_range(1, 32'h8000);
        sustainLevel = $urandom_range(0, 32'h1_8000);
        case ($urandom_range(0, 3))
          0:       releaseRate = 32'h0;
          1:       releaseRate = 32'hFFFF_FFFF;
          default: releaseRate = $urandom_range(1, 32'h8000);
        endcase
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
